cok_yollu_bellek_ctrl: RTL and testbench

- Second-generation dual-port synchronous RAM block for the memory subsystem.
- Splits each port's bidirectional bus into separate write/read buses and adds a req/ready handshake and per-byte write enables.
- Adds registered reads with a valid strobe, a post-reset zero-fill sweep, and same-address write-collision arbitration with a counter.
- Sits between two independent masters (e.g. CPU and DMA) and a shared word store.

---
 rtl/cok_yollu_bellek_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_cok_yollu_bellek_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cok_yollu_bellek_ctrl.sv
// cok_yollu_bellek_ctrl: dual-port synchronous word store with req/ready handshake,
// per-byte write enables, registered reads with a one-cycle valid strobe, a zero-fill
// sweep after reset or clr, and same-address write arbitration (port A wins).
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   clr               synchronous pulse, restarts the zero-fill sweep
//   a_*/b_*           per-port req/we/addr/wdata/be inputs, ready/rdata/rvalid outputs
//   init_done         high once the zero-fill sweep has completed
//   coll_cnt          saturating count of port-B writes dropped by a same-address collision
//
// Optional feature: define COK_YOLLU_BELLEK_BYPASS_EN for write-to-read forwarding when
// one port reads the address the other port writes in the same cycle.
module cok_yollu_bellek_ctrl #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    input  logic [DATA_WIDTH/8-1:0] a_be,
    output logic                    a_ready,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    output logic                    a_rvalid,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [ADDR_WIDTH-1:0]   b_addr,
    input  logic [DATA_WIDTH-1:0]   b_wdata,
    input  logic [DATA_WIDTH/8-1:0] b_be,
    output logic                    b_ready,
    output logic [DATA_WIDTH-1:0]   b_rdata,
    output logic                    b_rvalid,
    output logic                    init_done,
    output logic [CNT_WIDTH-1:0]    coll_cnt
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                  st_q, st_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    a_rvalid_q, a_rvalid_d, b_rvalid_q, b_rvalid_d;
    logic [DATA_WIDTH-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [CNT_WIDTH-1:0]    coll_cnt_q, coll_cnt_d;

    logic                    a_in, b_in, a_wr, b_wr_raw, b_wr, a_rd, b_rd, coll;
    logic [DATA_WIDTH-1:0]   a_word, b_word;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= StInit;
            ptr_q <= '0;
        end else begin
            st_q  <= st_d;
            ptr_q <= ptr_d;
        end
    end

    // Next state: sweep one word per cycle; leave INIT on the cycle the last word is written
    always_comb begin
        st_d  = st_q;
        ptr_d = ptr_q;
        unique case (st_q)
            StInit: begin
                if (clr) begin
                    ptr_d = '0;
                end else if (32'(ptr_q) == DEPTH - 1) begin
                    st_d  = StRun;
                    ptr_d = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            StRun: begin
                if (clr) begin
                    st_d  = StInit;
                    ptr_d = '0;
                end
            end
            default: st_d = StInit;
        endcase
    end

    // FSM outputs
    always_comb begin
        a_ready   = 1'b0;
        b_ready   = 1'b0;
        init_done = 1'b0;
        if (st_q == StRun) begin
            a_ready   = 1'b1;
            b_ready   = 1'b1;
            init_done = 1'b1;
        end
    end

    // Request decode and collision arbitration
    always_comb begin
        a_in     = 32'(a_addr) < DEPTH;
        b_in     = 32'(b_addr) < DEPTH;
        a_wr     = a_req & a_ready & a_we & a_in;
        b_wr_raw = b_req & b_ready & b_we & b_in;
        a_rd     = a_req & a_ready & ~a_we;
        b_rd     = b_req & b_ready & ~b_we;
        coll     = a_wr & b_wr_raw & (a_addr == b_addr);
        b_wr     = b_wr_raw & ~coll;
    end

    // Read path: old word, optionally patched with the other port's same-cycle write
    always_comb begin
        a_word = a_in ? mem_q[a_addr] : '0;
        b_word = b_in ? mem_q[b_addr] : '0;
`ifdef COK_YOLLU_BELLEK_BYPASS_EN
        for (int i = 0; i < NumBytes; i++) begin
            if (b_wr && a_in && (b_addr == a_addr) && b_be[i]) begin
                a_word[8*i +: 8] = b_wdata[8*i +: 8];
            end
            if (a_wr && b_in && (a_addr == b_addr) && a_be[i]) begin
                b_word[8*i +: 8] = a_wdata[8*i +: 8];
            end
        end
`endif
        a_rvalid_d = a_rd;
        b_rvalid_d = b_rd;
        a_rdata_d  = a_rd ? a_word : a_rdata_q;
        b_rdata_d  = b_rd ? b_word : b_rdata_q;
        coll_cnt_d = coll_cnt_q;
        if (coll && (coll_cnt_q != '1)) begin
            coll_cnt_d = coll_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            coll_cnt_q <= '0;
        end else begin
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            coll_cnt_q <= coll_cnt_d;
        end
    end

    // Word store has no reset; the sweep zero-fills it. Ports are never ready during INIT.
    always_ff @(posedge clk) begin
        if (st_q == StInit) begin
            mem_q[ptr_q] <= '0;
        end else begin
            for (int i = 0; i < NumBytes; i++) begin
                if (a_wr && a_be[i]) begin
                    mem_q[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
                end
                if (b_wr && b_be[i]) begin
                    mem_q[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
                end
            end
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign coll_cnt = coll_cnt_q;

endmodule

// File: tb/tb_cok_yollu_bellek_ctrl.sv
// Self-checking bench for cok_yollu_bellek_ctrl: vector table plus directed sequences for
// the sweep length, collision saturation, clr restart and reset during a read.
module tb_cok_yollu_bellek_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, clr;
    logic        a_req, a_we, b_req, b_we;
    logic [3:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic [1:0]  a_be, b_be;
    logic        a_ready, a_rvalid, b_ready, b_rvalid, init_done;
    logic [15:0] a_rdata, b_rdata;
    logic [7:0]  coll_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cok_yollu_bellek_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_be      (a_be),
        .a_ready   (a_ready),
        .a_rdata   (a_rdata),
        .a_rvalid  (a_rvalid),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_be      (b_be),
        .b_ready   (b_ready),
        .b_rdata   (b_rdata),
        .b_rvalid  (b_rvalid),
        .init_done (init_done),
        .coll_cnt  (coll_cnt)
    );

`ifdef COK_YOLLU_BELLEK_BYPASS_EN
    localparam logic [15:0] V9A  = 16'hFFFF;
    localparam logic [15:0] V18A = 16'h00EF;
    localparam logic [15:0] V20B = 16'h12EF;
`else
    localparam logic [15:0] V9A  = 16'h0F0F;
    localparam logic [15:0] V18A = 16'hBEEF;
    localparam logic [15:0] V20B = 16'h00EF;
`endif

    typedef struct {
        logic        a_req, a_we;
        logic [3:0]  a_addr;
        logic [15:0] a_wdata;
        logic [1:0]  a_be;
        logic        b_req, b_we;
        logic [3:0]  b_addr;
        logic [15:0] b_wdata;
        logic [1:0]  b_be;
        logic        e_arv;
        logic [15:0] e_ard;
        logic        e_brv;
        logic [15:0] e_brd;
        logic [7:0]  e_coll;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Counts edges from now until init_done; the sweep must take exactly 16
    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 100) begin
            step();
            n++;
        end
        check(name, n, 16);
    endtask

    initial begin
        //                 a: req  we    addr   wdata      be      b: req  we    addr   wdata      be      arv   ard        brv   brd        coll
        vecs[0]  = '{1'b1, 1'b1, 4'd3, 16'hBEEF, 2'b11, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 16'h0000, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'hBEEF, 8'd0};
        vecs[2]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 1'b1, 4'd5, 16'hAAAA, 2'b11, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 8'd0};
        vecs[4]  = '{1'b1, 1'b1, 4'd5, 16'h1234, 2'b01, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b0, 16'hBEEF, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 4'd5, 16'h0000, 2'b00, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 16'hAA34, 1'b0, 16'hBEEF, 8'd0};
        vecs[6]  = '{1'b1, 1'b1, 4'd7, 16'h1111, 2'b11, 1'b1, 1'b1, 4'd7, 16'h2222, 2'b11, 1'b0, 16'hAA34, 1'b0, 16'hBEEF, 8'd1};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 1'b0, 4'd7, 16'h0000, 2'b00, 1'b0, 16'hAA34, 1'b1, 16'h1111, 8'd1};
        vecs[8]  = '{1'b1, 1'b1, 4'd9, 16'h0F0F, 2'b11, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 16'hAA34, 1'b0, 16'h1111, 8'd1};
        vecs[9]  = '{1'b1, 1'b0, 4'd9, 16'h0000, 2'b00, 1'b1, 1'b1, 4'd9, 16'hFFFF, 2'b11, 1'b1, V9A,      1'b0, 16'h1111, 8'd1};
        vecs[10] = '{1'b1, 1'b0, 4'd9, 16'h0000, 2'b00, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 16'hFFFF, 1'b0, 16'h1111, 8'd1};
        vecs[11] = '{1'b1, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b1, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b1, 16'hBEEF, 1'b1, 16'hBEEF, 8'd1};
        vecs[12] = '{1'b1, 1'b1, 4'd1, 16'h0101, 2'b11, 1'b1, 1'b1, 4'd2, 16'h0202, 2'b10, 1'b0, 16'hBEEF, 1'b0, 16'hBEEF, 8'd1};
        vecs[13] = '{1'b1, 1'b0, 4'd1, 16'h0000, 2'b00, 1'b1, 1'b0, 4'd2, 16'h0000, 2'b00, 1'b1, 16'h0101, 1'b1, 16'h0200, 8'd1};
        vecs[14] = '{1'b1, 1'b1, 4'd4, 16'hFFFF, 2'b00, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 16'h0101, 1'b0, 16'h0200, 8'd1};
        vecs[15] = '{1'b1, 1'b0, 4'd4, 16'h0000, 2'b00, 1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 16'h0000, 1'b0, 16'h0200, 8'd1};
        vecs[16] = '{1'b1, 1'b1, 4'd6, 16'h00AA, 2'b01, 1'b1, 1'b1, 4'd6, 16'hBB00, 2'b10, 1'b0, 16'h0000, 1'b0, 16'h0200, 8'd2};
        vecs[17] = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 1'b0, 4'd6, 16'h0000, 2'b00, 1'b0, 16'h0000, 1'b1, 16'h00AA, 8'd2};
        vecs[18] = '{1'b1, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b1, 1'b1, 4'd3, 16'h0000, 2'b10, 1'b1, V18A,     1'b0, 16'h00AA, 8'd2};
        vecs[19] = '{1'b0, 1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b0, V18A,     1'b1, 16'h00EF, 8'd2};
        vecs[20] = '{1'b1, 1'b1, 4'd3, 16'h1200, 2'b10, 1'b1, 1'b0, 4'd3, 16'h0000, 2'b00, 1'b0, V18A,     1'b1, V20B,     8'd2};

        rst_n = 1'b0;
        clr   = 1'b0;
        idle();
        step();
        step();
        check("rst a_ready", a_ready, 0);
        check("rst b_ready", b_ready, 0);
        check("rst a_rvalid", a_rvalid, 0);
        check("rst b_rvalid", b_rvalid, 0);
        check("rst init_done", init_done, 0);
        check("rst a_rdata", a_rdata, 0);
        check("rst b_rdata", b_rdata, 0);
        check("rst coll_cnt", coll_cnt, 0);

        rst_n = 1'b1;
        wait_init("sweep length after reset");

        // Every word zero-filled, each read a one-cycle rvalid pulse
        for (int i = 0; i < 16; i++) begin
            b_req = 1'b1; b_we = 1'b0; b_addr = 4'(i);
            step();
            check($sformatf("sweep b_rvalid %0d", i), b_rvalid, 1);
            check($sformatf("sweep b_rdata %0d", i), b_rdata, 0);
        end
        idle();
        step();
        check("sweep b_rvalid drop", b_rvalid, 0);

        for (int i = 0; i < NV; i++) begin
            a_req = vecs[i].a_req; a_we = vecs[i].a_we; a_addr = vecs[i].a_addr;
            a_wdata = vecs[i].a_wdata; a_be = vecs[i].a_be;
            b_req = vecs[i].b_req; b_we = vecs[i].b_we; b_addr = vecs[i].b_addr;
            b_wdata = vecs[i].b_wdata; b_be = vecs[i].b_be;
            step();
            check($sformatf("v%0d a_rvalid", i), a_rvalid, vecs[i].e_arv);
            check($sformatf("v%0d a_rdata", i), a_rdata, vecs[i].e_ard);
            check($sformatf("v%0d b_rvalid", i), b_rvalid, vecs[i].e_brv);
            check($sformatf("v%0d b_rdata", i), b_rdata, vecs[i].e_brd);
            check($sformatf("v%0d coll_cnt", i), coll_cnt, vecs[i].e_coll);
        end
        idle();
        step();

        // Collision counter saturation, starting from 2
        a_req = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 16'h1111; a_be = 2'b11;
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_wdata = 16'h2222; b_be = 2'b11;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 251) check("coll_cnt before saturation", coll_cnt, 254);
        end
        check("coll_cnt saturated", coll_cnt, 255);
        idle();
        a_req = 1'b1; a_addr = 4'd7;
        step();
        check("addr7 after collisions", a_rdata, 16'h1111);

        // clr restarts the sweep; requests during it must be ignored
        idle();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr a_ready drop", a_ready, 0);
        check("clr init_done drop", init_done, 0);
        b_req = 1'b1; b_we = 1'b1; b_addr = 4'd0; b_wdata = 16'hFFFF; b_be = 2'b11;
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd0;
        begin
            int n = 0;
            int rv_seen = 0;
            while (!a_ready && n < 100) begin
                step();
                n++;
                if (a_rvalid || b_rvalid) rv_seen++;
            end
            check("clr sweep length", n, 16);
            check("clr rvalid while not ready", rv_seen, 0);
        end
        idle();
        check("clr keeps coll_cnt", coll_cnt, 255);
        for (int i = 0; i < 16; i++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = 4'(i);
            step();
            if (a_rdata !== 16'h0000 || a_rvalid !== 1'b1)
                check($sformatf("post-clr addr %0d", i), {a_rvalid, a_rdata}, {1'b1, 16'h0000});
            else
                checks++;
        end
        idle();

        // Reset right after a read is accepted cancels the pending rvalid
        a_req = 1'b1; a_we = 1'b0; a_addr = 4'd3;
        @(posedge clk);
        #1 rst_n = 1'b0;
        idle();
        @(negedge clk);
        check("mid-read reset a_rvalid", a_rvalid, 0);
        check("mid-read reset a_rdata", a_rdata, 0);
        check("mid-read reset coll_cnt", coll_cnt, 0);
        check("mid-read reset a_ready", a_ready, 0);
        step();
        rst_n = 1'b1;
        wait_init("sweep length after mid-read reset");
        check("a_rvalid stays low", a_rvalid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
